branch_resolve_unit: RTL and testbench

//  EX-side counterpart of the IF branch predictor. Carries each fetch's prediction (pTaken/pTarget) through IF/ID
//  and ID/EX, resolves the real outcome in EX, and on mismatch flushes younger stages and holds a redirect PC until
//  IF accepts it. Drives the predictor's training port (EX_bType/EX_rTaken/EX_bTarget) and mispredict perf counters.

---
 rtl/branch_resolve_if.sv | 45 ++++
 rtl/branch_resolve_unit.sv | 132 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// Pipeline-side bundle of the branch resolve unit: IF/EX inputs, redirect/flush/training outputs.
// The master drives the pipeline inputs; the resolve unit attaches as slave.
interface branch_resolve_if #(parameter int PERF_W = 32);
    logic              IF_DONE;
    logic              MEM_DONE;
    logic              DMA_interrupt;
    logic              WTO_interrupt;
    logic              IF_valid;
    logic              IF_pTaken;
    logic [31:0]       IF_pTarget;
    logic              EX_valid;
    logic              EX_isBranch;
    logic              EX_isJAL;
    logic              EX_isJALR;
    logic              EX_cmpTaken;
    logic [31:0]       EX_PC;
    logic [31:0]       EX_imm;
    logic [31:0]       EX_rs1;
    logic              flush;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic [1:0]        EX_bType;
    logic              EX_rTaken;
    logic [31:0]       EX_bTarget;
    logic [PERF_W-1:0] branch_cnt;
    logic [PERF_W-1:0] mispred_cnt;

    modport master (
        output IF_DONE, MEM_DONE, DMA_interrupt, WTO_interrupt,
               IF_valid, IF_pTaken, IF_pTarget,
               EX_valid, EX_isBranch, EX_isJAL, EX_isJALR, EX_cmpTaken,
               EX_PC, EX_imm, EX_rs1,
        input  flush, redirect_valid, redirect_pc,
               EX_bType, EX_rTaken, EX_bTarget, branch_cnt, mispred_cnt
    );

    modport slave (
        input  IF_DONE, MEM_DONE, DMA_interrupt, WTO_interrupt,
               IF_valid, IF_pTaken, IF_pTarget,
               EX_valid, EX_isBranch, EX_isJAL, EX_isJALR, EX_cmpTaken,
               EX_PC, EX_imm, EX_rs1,
        output flush, redirect_valid, redirect_pc,
               EX_bType, EX_rTaken, EX_bTarget, branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Carries IF predictions down to EX, resolves the real control-flow outcome, flushes on mispredict
// and holds the corrected fetch PC until IF takes it; also feeds predictor training and perf counters.
module branch_resolve_unit #(
    parameter int PERF_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    branch_resolve_if.slave bus
);
    typedef struct packed {
        logic        valid;
        logic        ptaken;
        logic [31:0] ptarget;
    } pred_t;

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t            state_q, state_d;
    pred_t             ifid_q, ifid_d;
    pred_t             idex_q, idex_d;
    logic [31:0]       redirect_pc_q, redirect_pc_d;
    logic [PERF_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [PERF_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic        adv, trap, idle;
    logic        ctl, taken, mis, resolve, flush;
    logic [31:0] tgt, seq_pc, act_next, pred_next;

    assign adv  = bus.IF_DONE && bus.MEM_DONE;
    assign trap = bus.DMA_interrupt || bus.WTO_interrupt;

    always_comb begin
        ctl       = bus.EX_isBranch | bus.EX_isJAL | bus.EX_isJALR;
        seq_pc    = bus.EX_PC + 32'd4;
        tgt       = bus.EX_isJALR ? ((bus.EX_rs1 + bus.EX_imm) & ~32'd1)
                                  : (bus.EX_PC + bus.EX_imm);
        taken     = bus.EX_isJAL | bus.EX_isJALR | (bus.EX_isBranch & bus.EX_cmpTaken);
        act_next  = taken ? tgt : seq_pc;
        pred_next = idex_q.ptaken ? idex_q.ptarget : seq_pc;
        // Only instructions fetched with a live prediction take part in resolution.
        resolve   = bus.EX_valid && idex_q.valid;
        mis       = resolve && (act_next != pred_next);
        flush     = mis && adv && idle;
    end

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        if (trap) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (flush)       state_d = HOLD;
                HOLD:    if (bus.IF_DONE) state_d = IDLE;
                default:                  state_d = IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        idle               = (state_q == IDLE);
        bus.redirect_valid = (state_q == HOLD);
    end

    always_comb begin
        ifid_d        = ifid_q;
        idex_d        = idex_q;
        redirect_pc_d = redirect_pc_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (trap) begin
            ifid_d = '0;
            idex_d = '0;
        end else begin
            if (flush) begin
                ifid_d        = '0;
                idex_d        = '0;
                redirect_pc_d = act_next;
            end else if (adv) begin
                // Fetches during HOLD are on the wrong path and must never resolve.
                ifid_d = '{valid: bus.IF_valid && idle, ptaken: bus.IF_pTaken,
                           ptarget: bus.IF_pTarget};
                idex_d = ifid_q;
            end
            if (adv && resolve) begin
                if (!(&branch_cnt_q))  branch_cnt_d  = branch_cnt_q + PERF_W'(ctl);
                if (!(&mispred_cnt_q)) mispred_cnt_d = mispred_cnt_q + PERF_W'(mis);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifid_q        <= '0;
            idex_q        <= '0;
            redirect_pc_q <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            ifid_q        <= ifid_d;
            idex_q        <= idex_d;
            redirect_pc_q <= redirect_pc_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    always_comb begin
        bus.flush       = flush;
        bus.redirect_pc = redirect_pc_q;
        bus.branch_cnt  = branch_cnt_q;
        bus.mispred_cnt = mispred_cnt_q;
        bus.EX_bType    = 2'b00;
        bus.EX_rTaken   = 1'b0;
        bus.EX_bTarget  = 32'd0;
        if (bus.EX_valid) begin
            bus.EX_rTaken  = taken;
            bus.EX_bTarget = tgt;
            if (idex_q.valid) begin
                if (bus.EX_isBranch)   bus.EX_bType = 2'b10;
                else if (bus.EX_isJAL) bus.EX_bType = 2'b01;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with 4-bit counters so saturation is reachable.
module tb_branch_resolve_unit;
    localparam int PW = 4;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    branch_resolve_if #(.PERF_W(PW)) bus ();

    branch_resolve_unit #(.PERF_W(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_set(input logic v, input logic b, input logic jal, input logic jalr,
                          input logic cmp, input logic [31:0] pc, input logic [31:0] imm,
                          input logic [31:0] rs1);
        bus.EX_valid    = v;
        bus.EX_isBranch = b;
        bus.EX_isJAL    = jal;
        bus.EX_isJALR   = jalr;
        bus.EX_cmpTaken = cmp;
        bus.EX_PC       = pc;
        bus.EX_imm      = imm;
        bus.EX_rs1      = rs1;
    endtask

    // Pushes the same prediction into IF/ID and ID/EX with EX idle.
    task automatic load_pred(input logic pt, input logic [31:0] ptgt);
        ex_set(0, 0, 0, 0, 0, 0, 0, 0);
        bus.IF_DONE    = 1'b1;
        bus.MEM_DONE   = 1'b1;
        bus.IF_valid   = 1'b1;
        bus.IF_pTaken  = pt;
        bus.IF_pTarget = ptgt;
        tick();
        tick();
        bus.IF_valid   = 1'b0;
        bus.IF_pTaken  = 1'b0;
        bus.IF_pTarget = 32'd0;
    endtask

    task automatic release_hold();
        ex_set(0, 0, 0, 0, 0, 0, 0, 0);
        bus.IF_DONE = 1'b1;
        tick();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        bus.IF_DONE = 1'b1;     bus.MEM_DONE = 1'b1;
        bus.DMA_interrupt = 1'b0; bus.WTO_interrupt = 1'b0;
        bus.IF_valid = 1'b0;    bus.IF_pTaken = 1'b0; bus.IF_pTarget = 32'd0;
        ex_set(0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
        chk("rst_branch_cnt", 32'(bus.branch_cnt), 32'd0);
        chk("rst_mispred_cnt", 32'(bus.mispred_cnt), 32'd0);
        chk("rst_flush", 32'(bus.flush), 32'd0);
        rst = 1'b0;
        tick();

        // 1: taken B-type predicted not-taken
        load_pred(1'b0, 32'd0);
        ex_set(1, 1, 0, 0, 1, 32'h100, 32'h20, 32'd0);
        #1;
        chk("t1_flush", 32'(bus.flush), 32'd1);
        chk("t1_btype", 32'(bus.EX_bType), 32'd2);
        chk("t1_rtaken", 32'(bus.EX_rTaken), 32'd1);
        chk("t1_btarget", bus.EX_bTarget, 32'h120);
        tick();
        chk("t1_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        chk("t1_redirect_pc", bus.redirect_pc, 32'h120);
        chk("t1_mispred_cnt", 32'(bus.mispred_cnt), 32'd1);
        chk("t1_branch_cnt", 32'(bus.branch_cnt), 32'd1);
        release_hold();
        chk("t1_redirect_drop", 32'(bus.redirect_valid), 32'd0);

        // 2: same branch, correctly predicted
        load_pred(1'b1, 32'h120);
        ex_set(1, 1, 0, 0, 1, 32'h100, 32'h20, 32'd0);
        #1;
        chk("t2_flush", 32'(bus.flush), 32'd0);
        tick();
        chk("t2_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        chk("t2_branch_cnt", 32'(bus.branch_cnt), 32'd2);
        chk("t2_mispred_cnt", 32'(bus.mispred_cnt), 32'd1);

        // 3: JALR target has bit 0 cleared
        load_pred(1'b0, 32'd0);
        ex_set(1, 0, 0, 1, 0, 32'h300, 32'h4, 32'h2003);
        #1;
        chk("t3_flush", 32'(bus.flush), 32'd1);
        chk("t3_btype", 32'(bus.EX_bType), 32'd0);
        chk("t3_btarget", bus.EX_bTarget, 32'h2006);
        tick();
        chk("t3_redirect_pc", bus.redirect_pc, 32'h2006);
        chk("t3_branch_cnt", 32'(bus.branch_cnt), 32'd3);
        chk("t3_mispred_cnt", 32'(bus.mispred_cnt), 32'd2);
        release_hold();

        // 4: non-control instr with aliased taken prediction; IF stalls the redirect
        load_pred(1'b1, 32'h400);
        ex_set(1, 0, 0, 0, 0, 32'h200, 32'h0, 32'd0);
        #1;
        chk("t4_flush", 32'(bus.flush), 32'd1);
        chk("t4_rtaken", 32'(bus.EX_rTaken), 32'd0);
        tick();
        chk("t4_redirect_pc", bus.redirect_pc, 32'h204);
        chk("t4_mispred_cnt", 32'(bus.mispred_cnt), 32'd3);
        chk("t4_branch_cnt", 32'(bus.branch_cnt), 32'd3);
        bus.IF_DONE = 1'b0;
        ex_set(1, 1, 0, 0, 1, 32'h500, 32'h40, 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_hold_flush", 32'(bus.flush), 32'd0);
            tick();
            chk("t4_hold_valid", 32'(bus.redirect_valid), 32'd1);
        end
        bus.IF_DONE = 1'b1;
        #1;
        chk("t4_hold_flush_adv", 32'(bus.flush), 32'd0);
        tick();
        chk("t4_redirect_drop", 32'(bus.redirect_valid), 32'd0);
        chk("t4_mispred_hold", 32'(bus.mispred_cnt), 32'd3);
        ex_set(0, 0, 0, 0, 0, 0, 0, 0);

        // 5: MEM stall postpones the flush, then WTO in HOLD drops the redirect
        load_pred(1'b0, 32'd0);
        bus.MEM_DONE = 1'b0;
        ex_set(1, 1, 0, 0, 1, 32'h100, 32'h20, 32'd0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t5_stall_flush", 32'(bus.flush), 32'd0);
            tick();
            chk("t5_stall_mispred", 32'(bus.mispred_cnt), 32'd3);
        end
        bus.MEM_DONE = 1'b1;
        #1;
        chk("t5_flush", 32'(bus.flush), 32'd1);
        tick();
        chk("t5_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        chk("t5_mispred_cnt", 32'(bus.mispred_cnt), 32'd4);
        chk("t5_branch_cnt", 32'(bus.branch_cnt), 32'd4);
        ex_set(0, 0, 0, 0, 0, 0, 0, 0);
        bus.IF_DONE = 1'b0;
        bus.WTO_interrupt = 1'b1;
        tick();
        bus.WTO_interrupt = 1'b0;
        chk("t5_wto_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        chk("t5_wto_redirect_pc", bus.redirect_pc, 32'h120);
        chk("t5_wto_mispred_cnt", 32'(bus.mispred_cnt), 32'd4);
        bus.IF_DONE = 1'b1;

        // DMA trap with live predictions in IF/ID and ID/EX discards both
        load_pred(1'b0, 32'd0);
        bus.DMA_interrupt = 1'b1;
        tick();
        bus.DMA_interrupt = 1'b0;
        ex_set(1, 1, 0, 0, 1, 32'h100, 32'h20, 32'd0);
        #1;
        chk("dma_idex_flush", 32'(bus.flush), 32'd0);
        chk("dma_idex_btype", 32'(bus.EX_bType), 32'd0);
        tick();
        chk("dma_ifid_flush", 32'(bus.flush), 32'd0);
        tick();
        chk("dma_mispred_cnt", 32'(bus.mispred_cnt), 32'd4);
        chk("dma_branch_cnt", 32'(bus.branch_cnt), 32'd4);

        // Saturation: 14 more mispredicted branches push both 4-bit counters past 15
        for (int i = 0; i < 14; i++) begin
            load_pred(1'b0, 32'd0);
            ex_set(1, 1, 0, 0, 1, 32'h100, 32'h20, 32'd0);
            tick();
            release_hold();
        end
        chk("sat_branch_cnt", 32'(bus.branch_cnt), 32'hF);
        chk("sat_mispred_cnt", 32'(bus.mispred_cnt), 32'hF);
        load_pred(1'b0, 32'd0);
        ex_set(1, 1, 0, 0, 1, 32'h100, 32'h20, 32'd0);
        tick();
        chk("sat_hold_redirect", 32'(bus.redirect_valid), 32'd1);
        chk("sat_hold_mispred", 32'(bus.mispred_cnt), 32'hF);

        // Asynchronous reset in the middle of HOLD
        ex_set(0, 0, 0, 0, 0, 0, 0, 0);
        bus.IF_DONE = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rst_hold_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        chk("rst_hold_redirect_pc", bus.redirect_pc, 32'd0);
        chk("rst_hold_mispred_cnt", 32'(bus.mispred_cnt), 32'd0);
        chk("rst_hold_branch_cnt", 32'(bus.branch_cnt), 32'd0);
        rst = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
